// File: rtl/xbus_link.sv
// XBus rendezvous link: pairs one blocked writer with one blocked reader per transfer,
// using round-robin arbitration on both sides.
module xbus_link #(
    parameter int NPORTS = 2,
    parameter int W      = 11
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [NPORTS*W-1:0] dat_from_mc_i,
    input  logic [NPORTS-1:0]   wr_req_i,
    input  logic [NPORTS-1:0]   rd_req_i,
    output logic [NPORTS*W-1:0] dat_to_mc_o,
    output logic [NPORTS-1:0]   data_valid_o,
    output logic [NPORTS-1:0]   write_done_o,
    output logic [15:0]         xfer_count_o
);
    // state   | meaning
    // IDLE    | arbitrate writer/reader, latch word on a match
    // DELIVER | data_valid/write_done pulses visible for one cycle
    // RELEASE | wait for the served pair to drop both requests
    typedef enum logic [1:0] {IDLE, DELIVER, RELEASE} state_e;

    localparam int PW = 2;

    state_e              state_q, state_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]       wsel_q, wsel_d, rsel_q, rsel_d;
    logic [NPORTS*W-1:0] dat_q, dat_d;
    logic [NPORTS-1:0]   dv_q, dv_d, wd_q, wd_d;
    logic [15:0]         cnt_q, cnt_d;

    logic                wr_found, rd_found;
    logic [PW-1:0]       wr_pick, rd_pick;
    logic [W-1:0]        wr_word;
    logic [NPORTS-1:0]   wsel_oh, rsel_oh;
    int                  wr_best, rd_best, wr_dist, rd_dist;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(NPORTS - 1)) ? '0 : p + 1'b1;
    endfunction

    // Round-robin: the requester at the smallest upward distance from the pointer wins.
    always_comb begin
        wr_best = NPORTS;
        wr_dist = 0;
        wr_pick = '0;
        for (int i = 0; i < NPORTS; i++) begin
            wr_dist = i - int'(wr_ptr_q);
            if (wr_dist < 0) wr_dist = wr_dist + NPORTS;
            if (wr_req_i[i] && wr_dist < wr_best) begin
                wr_best = wr_dist;
                wr_pick = PW'(i);
            end
        end
        wr_found = (wr_best < NPORTS);
    end

    always_comb begin
        rd_best = NPORTS;
        rd_dist = 0;
        rd_pick = '0;
        for (int i = 0; i < NPORTS; i++) begin
            rd_dist = i - int'(rd_ptr_q);
            if (rd_dist < 0) rd_dist = rd_dist + NPORTS;
            if (rd_req_i[i] && PW'(i) != wr_pick && rd_dist < rd_best) begin
                rd_best = rd_dist;
                rd_pick = PW'(i);
            end
        end
        rd_found = (rd_best < NPORTS);
    end

    always_comb begin
        wr_word = '0;
        wsel_oh = '0;
        rsel_oh = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (PW'(i) == wr_pick) wr_word = dat_from_mc_i[i*W +: W];
            wsel_oh[i] = (PW'(i) == wsel_q);
            rsel_oh[i] = (PW'(i) == rsel_q);
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        wsel_d   = wsel_q;
        rsel_d   = rsel_q;
        dat_d    = dat_q;
        dv_d     = '0;
        wd_d     = '0;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (wr_found && rd_found) begin
                    state_d  = DELIVER;
                    wsel_d   = wr_pick;
                    rsel_d   = rd_pick;
                    wr_ptr_d = next_ptr(wr_pick);
                    rd_ptr_d = next_ptr(rd_pick);
                    cnt_d    = cnt_q + 16'd1;
                    for (int i = 0; i < NPORTS; i++) begin
                        dv_d[i] = (PW'(i) == rd_pick);
                        wd_d[i] = (PW'(i) == wr_pick);
                        if (PW'(i) == rd_pick) dat_d[i*W +: W] = wr_word;
                    end
                end
            end
            DELIVER: state_d = RELEASE;
            RELEASE: begin
                if (!(|(wr_req_i & wsel_oh)) && !(|(rd_req_i & rsel_oh))) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            wsel_q   <= '0;
            rsel_q   <= '0;
            dat_q    <= '0;
            dv_q     <= '0;
            wd_q     <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            wsel_q   <= wsel_d;
            rsel_q   <= rsel_d;
            dat_q    <= dat_d;
            dv_q     <= dv_d;
            wd_q     <= wd_d;
            cnt_q    <= cnt_d;
        end
    end

    assign dat_to_mc_o  = dat_q;
    assign data_valid_o = dv_q;
    assign write_done_o = wd_q;
    assign xfer_count_o = cnt_q;

endmodule
